fun_arbiter: RTL and testbench
==============================

// Module: fun_arbiter
// PURPOSE
//  Shares one multicycle `fun` unit (result = a * cbrt(b), start/busy handshake) between N_REQ requesters.
//  Picks requesters round-robin, latches and holds the winner's operands for the whole operation,
//  and issues a one-cycle start. It then waits for busy to fall, returns the result with a one-cycle
//  per-requester ack, and bounds every operation with a timeout.
//  Sits between client blocks and the single `fun` instance; `fun` itself is unchanged.
// PARAMETERS
//  N_REQ    4     number of requesters (>=2)
//  A_W      8     operand a width
//  B_W      8     operand b width
//  R_W      11    result width
//  TIMEOUT  2000  max RUN cycles before the operation is abandoned (counter width $clog2(TIMEOUT+1))
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous, active-low reset
//  req_i       in   N_REQ      level request per requester; held until its ack
//  a_i         in   N_REQ*A_W  packed operands a, requester k at [k*A_W +: A_W]
//  b_i         in   N_REQ*B_W  packed operands b, same packing
//  grant_o     out  N_REQ      one-hot, owner of the current operation, 0 when idle
//  ack_o       out  N_REQ      one-cycle pulse to the owner when result_o is valid
//  result_o    out  R_W        result of the last completed operation, held until next ack
//  err_o       out  1          one-cycle pulse with ack_o when the operation timed out
//  busy_o      out  1          high from grant to ack inclusive
//  fun_a       out  A_W        operand a to fun, registered, stable for the whole operation
//  fun_b       out  B_W        operand b to fun, registered, stable for the whole operation
//  fun_start   out  1          start to fun, registered, exactly one cycle per operation
//  fun_busy    in   1          busy from fun
//  fun_result  in   R_W        result from fun, valid when fun_busy=0 after the operation
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=IDLE, RR pointer=N_REQ-1 (so requester 0 wins first),
//   timeout counter 0. A reset mid-operation abandons it: no ack, fun_start=0 immediately.
//  FSM: IDLE -> ISSUE -> RUN -> DONE -> IDLE.
//   IDLE: on an edge with |req_i, pick winner g = the first set bit after the pointer, wrapping.
//    On that edge register grant_o=onehot(g), fun_a/fun_b=operands of g, busy_o=1; go to ISSUE.
//   ISSUE: fun_start=1 for this cycle only; clear the counter; go to RUN.
//   RUN: ignore fun_busy in the first RUN cycle (guard for the fun busy rise).
//    From the second RUN cycle on, fun_busy=0 sampled -> result_o<=fun_result; go to DONE.
//    If the counter reaches TIMEOUT while fun_busy=1 -> result_o<=0, err_o<=1; go to DONE.
//   DONE: ack_o[g]=1 for one cycle. Then grant_o<=0, busy_o<=0, pointer<=g; go to IDLE.
//  Latency: from the req sample edge, fun_start is high in cycle +1.
//   Ack arrives no earlier than cycle +4; in general ack = +3 + (RUN cycles until fun_busy=0).
//  Back-to-back: IDLE lasts at least one cycle between operations; no new grant during ISSUE/RUN/DONE.
//  Fairness: with all requesters requesting continuously, grants rotate 0,1,..,N_REQ-1,0.
//   No requester waits more than N_REQ-1 operations.
//  req_i dropped after grant: the operation still completes and ack_o still pulses; no abort.
//  req_i still high in the cycle after its ack counts as a new request; it takes part in IDLE arbitration.
//  Simultaneous requests in IDLE: only one is granted, by round-robin order; the others stay pending.
//  Changes on a_i/b_i after grant have no effect; fun sees only the latched values.
//  Width rule: result_o is exactly R_W bits, no truncation (fun max 255*6=1530 < 2^11).
// STRUCTURE
//  fun_pkg.vh: A_W/B_W/R_W defaults, FSM state encodings (IDLE/ISSUE/RUN/DONE), TIMEOUT default.
//  Sub-module rr_arbiter (N_REQ): combinational first-set-after-pointer picker.
//   Inputs: req vector and pointer. Outputs: one-hot grant and index. The FSM owns the pointer register.
//  fun_arbiter holds the FSM, operand/result registers and the timeout counter. It does not instantiate fun.
// TESTING (bench instantiates fun_arbiter + fun; fun rst driven by ~rst)
//  1 Single op: req_i=0001, a0=5, b0=27
//    -> fun_start one cycle, grant_o=0001 held until the op ends, ack_o=0001 once, result_o=15, err_o=0.
//  2 Contention: req_i=1111 held, with (5,27), (3,64), (9,125), (255,200)
//    -> acks in order 0,1,2,3,0; results 15, 12, 45, 1275; never two grant bits set at once.
//  3 Pointer wrap: after grant to requester 2, req_i=0101
//    -> requester 0 is granted (wrap past 3), then requester 2.
//  4 Operand hold: change a0/b0 to (97,0) one cycle after grant
//    -> fun_a/fun_b unchanged for the whole op; result_o is from the original operands (e.g. 84,84 -> 336).
//  5 Timeout: stub fun_busy stuck at 1, TIMEOUT=20
//    -> ack_o and err_o pulse together, result_o=0, FSM returns to IDLE and serves the next request.
//  6 Reset mid-op: drive rst=0 during RUN
//    -> all outputs 0 asynchronously, no ack. After release, a (32,172) request -> result_o=160.

Source files
------------

// File: rtl/fun_arbiter_pkg.sv
// fun_arbiter_pkg: shared defaults and FSM encodings for the fun arbiter slice.
package fun_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int A_W_DEF     = 8;
  localparam int B_W_DEF     = 8;
  localparam int R_W_DEF     = 11;
  localparam int TIMEOUT_DEF = 2000;

  // FSM encodings kept as plain constants so older tools can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fun_arbiter_if.sv
// fun_arbiter_if: start/busy handshake and operand/result bus to the shared fun unit.
interface fun_arbiter_if
  import fun_arbiter_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int R_W = R_W_DEF
);

  logic [A_W-1:0] fun_a;
  logic [B_W-1:0] fun_b;
  logic           fun_start;
  logic           fun_busy;
  logic [R_W-1:0] fun_result;

  // arbiter side drives operands and start
  modport master (
    output fun_a,
    output fun_b,
    output fun_start,
    input  fun_busy,
    input  fun_result
  );

  // fun unit side
  modport slave (
    input  fun_a,
    input  fun_b,
    input  fun_start,
    output fun_busy,
    output fun_result
  );

endinterface

// File: rtl/fun_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set request strictly after
// the pointer, wrapping. The pointer register belongs to the caller.
module rr_arbiter
  import fun_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // scan the N_REQ candidates in priority order starting just after the pointer
  always_comb begin
    int   cand;
    logic take;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    take    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand           = (int'(ptr_i) + i) % N_REQ;
      take           = !valid_o && req_i[cand];
      grant_o[cand]  = take;
      idx_o          = take ? IDX_W'(cand) : idx_o;
      valid_o        = valid_o | take;
    end
  end

endmodule

// File: rtl/fun_arbiter.sv
// fun_arbiter: shares one multicycle fun unit (a * cbrt(b)) between N_REQ requesters.
// Round-robin pick, operands latched for the whole operation, one-cycle start,
// result returned with a one-cycle per-requester ack, every operation time-bounded.
module fun_arbiter
  import fun_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int R_W     = R_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ*A_W-1:0] a_i,
  input  logic [N_REQ*B_W-1:0] b_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic [N_REQ-1:0]     ack_o,
  output logic [R_W-1:0]       result_o,
  output logic                 err_o,
  output logic                 busy_o,
  fun_arbiter_if.master        fun_bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // counter value in the RUN cycle whose increment would reach TIMEOUT
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // pointer starts on the last requester so requester 0 wins first
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] ptr_q,    ptr_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic [N_REQ-1:0] ack_q,    ack_d;
  logic [R_W-1:0]   result_q, result_d;
  logic             err_q,    err_d;
  logic             busy_q,   busy_d;
  logic [A_W-1:0]   fun_a_q,  fun_a_d;
  logic [B_W-1:0]   fun_b_q,  fun_b_d;
  logic             start_q,  start_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [N_REQ-1:0] win_grant_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_valid_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (win_grant_s),
    .idx_o   (win_idx_s),
    .valid_o (win_valid_s)
  );

  // next-state logic for the IDLE -> ISSUE -> RUN -> DONE operation cycle
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    ack_d    = '0;
    result_d = result_q;
    err_d    = 1'b0;
    busy_d   = busy_q;
    fun_a_d  = fun_a_q;
    fun_b_d  = fun_b_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          grant_d = win_grant_s;
          idx_d   = win_idx_s;
          fun_a_d = a_i[win_idx_s*A_W +: A_W];
          fun_b_d = b_i[win_idx_s*B_W +: B_W];
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // cnt_q == 0 marks the first RUN cycle, where fun_busy may not have risen yet
        if ((cnt_q != '0) && !fun_bus.fun_busy) begin
          result_d = fun_bus.fun_result;
          ack_d    = grant_q;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          ack_d    = grant_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      idx_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      fun_a_q  <= '0;
      fun_b_q  <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      fun_a_q  <= fun_a_d;
      fun_b_q  <= fun_b_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant_o           = grant_q;
  assign ack_o             = ack_q;
  assign result_o          = result_q;
  assign err_o             = err_q;
  assign busy_o            = busy_q;
  assign fun_bus.fun_a     = fun_a_q;
  assign fun_bus.fun_b     = fun_b_q;
  assign fun_bus.fun_start = start_q;

endmodule

// File: tb/tb_fun_arbiter.sv
// tb_fun_arbiter: directed table, hand sequences and randomized traffic against a
// behavioural round-robin / a*cbrt(b) reference, with a behavioural fun unit.
module tb_fun_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int RW = 11;
  localparam int TO = 20;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] a_i;
  logic [N*BW-1:0] b_i;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    ack_o;
  logic [RW-1:0]   result_o;
  logic            err_o;
  logic            busy_o;

  fun_arbiter_if #(.A_W(AW), .B_W(BW), .R_W(RW)) fif ();

  fun_arbiter #(
    .N_REQ(N), .A_W(AW), .B_W(BW), .R_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .grant_o(grant_o), .ack_o(ack_o), .result_o(result_o), .err_o(err_o),
    .busy_o(busy_o), .fun_bus(fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: a * floor(cbrt(b))
  function automatic int ref_fun(input int a, input int b);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return a * r;
  endfunction

  // behavioural fun unit: busy rises on start, falls `lat` cycles later with the result
  bit stuck    = 1'b0;
  bit rand_lat = 1'b0;
  int lat_fix  = 1;
  int fcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fif.fun_busy   <= 1'b0;
      fif.fun_result <= '0;
      fcnt           <= 0;
    end else if (fif.fun_start) begin
      fif.fun_busy <= 1'b1;
      fcnt         <= rand_lat ? int'($urandom_range(1, 6)) : lat_fix;
    end else if (fif.fun_busy && !stuck) begin
      if (fcnt <= 1) begin
        fif.fun_busy   <= 1'b0;
        fif.fun_result <= RW'(ref_fun(int'(fif.fun_a), int'(fif.fun_b)));
      end else begin
        fcnt <= fcnt - 1;
      end
    end
  end

  // scoreboard: predicts the winner and result of every operation
  logic [N-1:0]    snap_req;
  logic [N*AW-1:0] snap_a;
  logic [N*BW-1:0] snap_b;
  logic [N-1:0]    prev_grant;
  bit              prev_ack;
  int              m_last = N - 1;
  int              m_win  = 0;
  int              m_res  = 0;
  int              m_starts = 0;
  bit              m_active = 1'b0;
  bit              m_err    = 1'b0;
  logic [AW-1:0]   m_a;
  logic [BW-1:0]   m_b;
  int              ack_who[$];
  int              ack_res[$];
  int              ack_err[$];

  always @(negedge clk) begin
    if (!rst) begin
      m_last     = N - 1;
      m_active   = 1'b0;
      prev_grant = '0;
      prev_ack   = 1'b0;
    end else begin
      check("grant_onehot0", 64'($onehot0(grant_o)), 64'd1);
      if (prev_ack) check("idle_gap", {grant_o, busy_o}, 64'd0);
      if (grant_o != '0 && prev_grant == '0) begin
        m_win = -1;
        for (int i = 1; i <= N; i++) begin
          if (m_win < 0 && snap_req[(m_last + i) % N]) m_win = (m_last + i) % N;
        end
        check("rr_grant", grant_o, (m_win < 0) ? 64'd0 : (64'd1 << m_win));
        if (m_win < 0) m_win = 0;
        m_a      = snap_a[m_win*AW +: AW];
        m_b      = snap_b[m_win*BW +: BW];
        m_err    = stuck;
        m_res    = stuck ? 0 : ref_fun(int'(m_a), int'(m_b));
        m_active = 1'b1;
        m_starts = 0;
      end
      if (fif.fun_start) begin
        check("start_in_op", 64'(m_active), 64'd1);
        m_starts++;
      end
      if (m_active) begin
        check("fun_a_hold", fif.fun_a, m_a);
        check("fun_b_hold", fif.fun_b, m_b);
        check("busy_in_op", busy_o, 64'd1);
      end
      if (ack_o != '0) begin
        check("ack_in_op", 64'(m_active), 64'd1);
        check("ack_owner", ack_o, 64'd1 << m_win);
        check("result", result_o, 64'(m_res));
        check("err", err_o, 64'(m_err));
        check("one_start", 64'(m_starts), 64'd1);
        for (int k = 0; k < N; k++) if (ack_o[k]) ack_who.push_back(k);
        ack_res.push_back(int'(result_o));
        ack_err.push_back(int'(err_o));
        m_last   = m_win;
        m_active = 1'b0;
      end else begin
        check("err_without_ack", err_o, 64'd0);
      end
      prev_grant = grant_o;
      prev_ack   = (ack_o != '0);
    end
    snap_req = req_i;
    snap_a   = a_i;
    snap_b   = b_i;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    a_i[k*AW +: AW] = AW'(a);
    b_i[k*BW +: BW] = BW'(b);
  endtask

  task automatic clear_q();
    ack_who.delete();
    ack_res.delete();
    ack_err.delete();
  endtask

  task automatic wait_acks(input int n, input bit drop, input int budget);
    int t;
    t = 0;
    while (ack_who.size() < n && t < budget) begin
      step();
      t++;
      if (drop) req_i = req_i & ~ack_o;
    end
    check("ack_wait_bound", 64'(ack_who.size() >= n), 64'd1);
  endtask

  typedef struct {
    int k;
    int a;
    int b;
    int exp_res;
  } vec_t;

  vec_t tbl[10];
  int   exp_who[5];
  int   exp_r[5];
  int   t;

  initial begin
    tbl[0] = '{0, 5, 27, 15};
    tbl[1] = '{1, 3, 64, 12};
    tbl[2] = '{2, 9, 125, 45};
    tbl[3] = '{3, 255, 200, 1275};
    tbl[4] = '{1, 84, 84, 336};
    tbl[5] = '{2, 32, 172, 160};
    tbl[6] = '{0, 255, 255, 1530};
    tbl[7] = '{2, 0, 0, 0};
    tbl[8] = '{0, 1, 1, 1};
    tbl[9] = '{3, 255, 0, 0};
    exp_who = '{0, 1, 2, 3, 0};
    exp_r   = '{15, 12, 45, 1275, 15};

    req_i = '0;
    a_i   = '0;
    b_i   = '0;
    rst   = 1'b1;
    #1 rst = 1'b0;
    step();
    step();
    check("reset_outputs", {grant_o, ack_o, result_o, err_o, busy_o}, 64'd0);
    check("reset_fun_bus", {fif.fun_a, fif.fun_b, fif.fun_start}, 64'd0);
    rst = 1'b1;
    step();

    // single-requester table: grant, start latency, ack latency, result
    lat_fix = 1;
    for (int i = 0; i < 10; i++) begin
      set_op(tbl[i].k, tbl[i].a, tbl[i].b);
      req_i = N'(1) << tbl[i].k;
      step();
      check("t_start", fif.fun_start, 64'd1);
      check("t_grant", grant_o, 64'd1 << tbl[i].k);
      check("t_busy", busy_o, 64'd1);
      t = 0;
      while (ack_o == '0 && t < 20) begin
        step();
        t++;
      end
      check("t_ack_latency", 64'(t), 64'd3);
      check("t_ack", ack_o, 64'd1 << tbl[i].k);
      check("t_result", result_o, 64'(tbl[i].exp_res));
      check("t_err", err_o, 64'd0);
      req_i = '0;
      step();
      check("t_idle", {grant_o, busy_o, ack_o}, 64'd0);
      check("t_result_held", result_o, 64'(tbl[i].exp_res));
      step();
    end

    // contention: all four held continuously
    lat_fix = 2;
    set_op(0, 5, 27);
    set_op(1, 3, 64);
    set_op(2, 9, 125);
    set_op(3, 255, 200);
    clear_q();
    req_i = 4'b1111;
    wait_acks(5, 1'b0, 200);
    req_i = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < ack_who.size()) begin
        check("cont_order", 64'(ack_who[i]), 64'(exp_who[i]));
        check("cont_result", 64'(ack_res[i]), 64'(exp_r[i]));
      end
    end
    step();
    step();

    // pointer wrap: serve 2, then 0101 -> 0 then 2
    lat_fix = 1;
    clear_q();
    set_op(2, 4, 8);
    req_i = 4'b0100;
    wait_acks(1, 1'b1, 50);
    check("wrap_first", 64'(ack_who[0]), 64'd2);
    step();
    clear_q();
    set_op(0, 6, 8);
    set_op(2, 10, 27);
    req_i = 4'b0101;
    wait_acks(2, 1'b1, 100);
    if (ack_who.size() >= 2) begin
      check("wrap_a", 64'(ack_who[0]), 64'd0);
      check("wrap_b", 64'(ack_who[1]), 64'd2);
      check("wrap_res_a", 64'(ack_res[0]), 64'd12);
      check("wrap_res_b", 64'(ack_res[1]), 64'd30);
    end
    step();

    // operand hold: operands change one cycle after grant
    lat_fix = 4;
    clear_q();
    set_op(0, 84, 84);
    req_i = 4'b0001;
    step();
    step();
    set_op(0, 97, 0);
    wait_acks(1, 1'b1, 50);
    check("hold_result", 64'(ack_res[0]), 64'd336);
    step();

    // timeout: fun never drops busy
    stuck = 1'b1;
    clear_q();
    set_op(1, 10, 8);
    req_i = 4'b0010;
    step();
    t = 0;
    while (ack_o == '0 && t < TO + 10) begin
      step();
      t++;
    end
    check("to_latency", 64'(t >= TO && t <= TO + 2), 64'd1);
    check("to_ack", ack_o, 64'd2);
    check("to_err", err_o, 64'd1);
    check("to_result", result_o, 64'd0);
    req_i = '0;
    step();
    check("to_err_pulse", err_o, 64'd0);
    stuck = 1'b0;
    clear_q();
    set_op(3, 7, 64);
    req_i = 4'b1000;
    wait_acks(1, 1'b1, 60);
    check("to_next_who", 64'(ack_who[0]), 64'd3);
    check("to_next_res", 64'(ack_res[0]), 64'd28);
    check("to_next_err", 64'(ack_err[0]), 64'd0);
    step();

    // reset in the middle of RUN
    lat_fix = 6;
    clear_q();
    set_op(0, 50, 50);
    req_i = 4'b0001;
    step();
    step();
    step();
    #1 rst = 1'b0;
    #1;
    check("rst_outputs", {grant_o, ack_o, result_o, err_o, busy_o}, 64'd0);
    check("rst_fun_bus", {fif.fun_a, fif.fun_b, fif.fun_start}, 64'd0);
    req_i = '0;
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_no_ack", 64'(ack_who.size()), 64'd0);
    lat_fix = 2;
    set_op(0, 32, 172);
    req_i = 4'b0001;
    wait_acks(1, 1'b1, 50);
    check("rst_after_who", 64'(ack_who[0]), 64'd0);
    check("rst_after_res", 64'(ack_res[0]), 64'd160);
    step();

    // randomized traffic; the scoreboard checks every grant and ack
    rand_lat = 1'b1;
    clear_q();
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (req_i[k] && ack_o[k]) req_i[k] = 1'b0;
        if (!req_i[k] && cyc < 360 && $urandom_range(0, 3) == 0) begin
          set_op(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
          req_i[k] = 1'b1;
        end else if (req_i[k] && $urandom_range(0, 7) == 0) begin
          set_op(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
    end
    t = 0;
    while ((req_i != '0 || busy_o) && t < 200) begin
      step();
      req_i = req_i & ~ack_o;
      t++;
    end
    check("rand_drained", {req_i, busy_o}, 64'd0);
    check("rand_progress", 64'(ack_who.size() > 20), 64'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
